// File: rtl/issue_scheduler_if.sv
// Dispatch, wakeup, issue and flush signals between rename,
// the issue scheduler and the ALU.
interface issue_scheduler_if #(
    parameter int DEPTH = 8,
    parameter int TAGW  = 6
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            disp_valid;
    logic            disp_ready;
    logic [TAGW-1:0] disp_prd;
    logic [TAGW-1:0] disp_prs1;
    logic [TAGW-1:0] disp_prs2;
    logic            disp_rs1_rdy;
    logic            disp_rs2_rdy;
    logic [3:0]      disp_alu_ctrl;
    logic            disp_alu_src;
    logic [31:0]     disp_imm;
    logic [5:0]      disp_rob_idx;
    logic            wb_valid;
    logic [TAGW-1:0] wb_tag;
    logic            iss_valid;
    logic            iss_ready;
    logic [TAGW-1:0] iss_prd;
    logic [TAGW-1:0] iss_prs1;
    logic [TAGW-1:0] iss_prs2;
    logic [3:0]      iss_alu_ctrl;
    logic            iss_alu_src;
    logic [31:0]     iss_imm;
    logic [5:0]      iss_rob_idx;
    logic [OW-1:0]   occupancy;

    modport master (
        output flush, disp_valid, disp_prd, disp_prs1, disp_prs2,
        output disp_rs1_rdy, disp_rs2_rdy, disp_alu_ctrl,
        output disp_alu_src, disp_imm, disp_rob_idx,
        output wb_valid, wb_tag, iss_ready,
        input  disp_ready, iss_valid, iss_prd, iss_prs1, iss_prs2,
        input  iss_alu_ctrl, iss_alu_src, iss_imm, iss_rob_idx,
        input  occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_prd, disp_prs1, disp_prs2,
        input  disp_rs1_rdy, disp_rs2_rdy, disp_alu_ctrl,
        input  disp_alu_src, disp_imm, disp_rob_idx,
        input  wb_valid, wb_tag, iss_ready,
        output disp_ready, iss_valid, iss_prd, iss_prs1, iss_prs2,
        output iss_alu_ctrl, iss_alu_src, iss_imm, iss_rob_idx,
        output occupancy
    );
endinterface

// File: rtl/issue_scheduler.sv
// Unified ALU issue scheduler: tag wakeup, age-matrix oldest-first
// select, lowest-free-slot allocation.
module issue_scheduler #(
    parameter int DEPTH = 8,
    parameter int TAGW  = 6
) (
    input logic              clk,
    input logic              reset_n,
    issue_scheduler_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + 1;

    typedef struct packed {
        logic [TAGW-1:0] prd;
        logic [TAGW-1:0] prs1;
        logic [TAGW-1:0] prs2;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic [31:0]     imm;
        logic [5:0]      rob_idx;
    } entry_t;

    entry_t           pay_q [DEPTH];
    entry_t           pay_new;
    entry_t           sel_e;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rs1_q, rs1_d;
    logic [DEPTH-1:0] rs2_q, rs2_d;
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] sel;
    logic [OW-1:0]    occ_q, occ_d;
    logic [IW-1:0]    free_idx;
    logic             disp_fire;
    logic             iss_fire;
    logic             new_rs1;
    logic             new_rs2;

    // Row i of age_q has bit j set when entry i is older than entry j.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = valid_q[i] & rs1_q[i]
                    & (rs2_q[i] | pay_q[i].alu_src);
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = elig[i]
                   & ~|(elig & ~age_q[i] & ~(DEPTH'(1) << i));
        end
        sel_e = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) sel_e = pay_q[i];
        end
    end

    assign bus.iss_valid    = |elig;
    assign bus.iss_prd      = sel_e.prd;
    assign bus.iss_prs1     = sel_e.prs1;
    assign bus.iss_prs2     = sel_e.prs2;
    assign bus.iss_alu_ctrl = sel_e.alu_ctrl;
    assign bus.iss_alu_src  = sel_e.alu_src;
    assign bus.iss_imm      = sel_e.imm;
    assign bus.iss_rob_idx  = sel_e.rob_idx;
    assign bus.occupancy    = occ_q;
    assign bus.disp_ready   = (occ_q < OW'(DEPTH)) && !bus.flush;

    assign disp_fire = bus.disp_valid & bus.disp_ready;
    assign iss_fire  = bus.iss_valid & bus.iss_ready & ~bus.flush;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

    // Tag 0 is hardwired ready; a same-cycle broadcast is bypassed in.
    always_comb begin
        pay_new.prd      = bus.disp_prd;
        pay_new.prs1     = bus.disp_prs1;
        pay_new.prs2     = bus.disp_prs2;
        pay_new.alu_ctrl = bus.disp_alu_ctrl;
        pay_new.alu_src  = bus.disp_alu_src;
        pay_new.imm      = bus.disp_imm;
        pay_new.rob_idx  = bus.disp_rob_idx;
        new_rs1 = bus.disp_rs1_rdy || (bus.disp_prs1 == '0)
               || (bus.wb_valid && bus.wb_tag == bus.disp_prs1);
        new_rs2 = bus.disp_rs2_rdy || (bus.disp_prs2 == '0)
               || (bus.wb_valid && bus.wb_tag == bus.disp_prs2);
    end

    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        age_d   = age_q;
        occ_d   = occ_q + OW'(disp_fire) - OW'(iss_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.wb_valid && pay_q[i].prs1 == bus.wb_tag) rs1_d[i] = 1'b1;
            if (bus.wb_valid && pay_q[i].prs2 == bus.wb_tag) rs2_d[i] = 1'b1;
        end
        if (iss_fire) valid_d = valid_d & ~sel;
        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
            rs1_d[free_idx]   = new_rs1;
            rs2_d[free_idx]   = new_rs2;
            age_d[free_idx]   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i][free_idx] = valid_q[i];
            end
        end
        if (bus.flush) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (disp_fire) pay_q[free_idx] <= pay_new;
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed vector bench for issue_scheduler: table of single-cycle
// vectors followed by multi-cycle ordering, full and flush sequences.
module tb_issue_scheduler;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    issue_scheduler_if #(.DEPTH(8), .TAGW(6)) bus ();

    issue_scheduler #(.DEPTH(8), .TAGW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fl; int dv; int prd; int p1; int p2;
        int r1; int r2; int src; int rob;
        int wv; int wt; int ir;
        int e_dr; int e_iv; int e_prd; int e_p1; int e_p2;
        int e_src; int e_rob; int e_occ;
    } vec_t;

    vec_t vt [28];

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.disp_valid    = 1'b0;
        bus.disp_prd      = '0;
        bus.disp_prs1     = '0;
        bus.disp_prs2     = '0;
        bus.disp_rs1_rdy  = 1'b0;
        bus.disp_rs2_rdy  = 1'b0;
        bus.disp_alu_ctrl = '0;
        bus.disp_alu_src  = 1'b0;
        bus.disp_imm      = '0;
        bus.disp_rob_idx  = '0;
        bus.wb_valid      = 1'b0;
        bus.wb_tag        = '0;
        bus.iss_ready     = 1'b0;
    endtask

    task automatic disp(input int prd, input int p1, input int p2,
                        input int r1, input int r2, input int src,
                        input int rob);
        logic [5:0] t;
        t = 6'(prd);
        bus.disp_valid    = 1'b1;
        bus.disp_prd      = t;
        bus.disp_prs1     = 6'(p1);
        bus.disp_prs2     = 6'(p2);
        bus.disp_rs1_rdy  = 1'(r1);
        bus.disp_rs2_rdy  = 1'(r2);
        bus.disp_alu_src  = 1'(src);
        bus.disp_rob_idx  = 6'(rob);
        bus.disp_alu_ctrl = t[3:0];
        bus.disp_imm      = 32'h1000 + 32'(prd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [95:0] pack_exp(input vec_t v);
        logic [5:0]  prd;
        logic [3:0]  ctrl;
        logic [31:0] imm;
        prd  = 6'(v.e_prd);
        ctrl = (v.e_iv != 0) ? prd[3:0] : 4'd0;
        imm  = (v.e_iv != 0) ? 32'h1000 + 32'(v.e_prd) : 32'd0;
        return 96'({1'(v.e_dr), 1'(v.e_iv), prd, 6'(v.e_p1),
                    6'(v.e_p2), ctrl, 1'(v.e_src), imm,
                    6'(v.e_rob), 4'(v.e_occ)});
    endfunction

    function automatic logic [95:0] pack_act();
        return 96'({bus.disp_ready, bus.iss_valid, bus.iss_prd,
                    bus.iss_prs1, bus.iss_prs2, bus.iss_alu_ctrl,
                    bus.iss_alu_src, bus.iss_imm, bus.iss_rob_idx,
                    bus.occupancy});
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        // fl dv prd p1 p2 r1 r2 src rob wv wt ir | dr iv prd p1 p2 src rob occ
        vt[0]  = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[1]  = '{0,1, 5, 0, 0,0,0,0, 1,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[2]  = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,1, 1,1, 5,0, 0,0,1,1};
        vt[3]  = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[4]  = '{0,1,10, 7, 0,0,0,0, 2,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[5]  = '{0,1,11, 3, 4,1,1,0, 3,0, 0,0, 1,0, 0,0, 0,0,0,1};
        vt[6]  = '{0,0, 0, 0, 0,0,0,0, 0,1, 7,1, 1,1,11,3, 4,0,3,2};
        vt[7]  = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,1,10,7, 0,0,2,1};
        vt[8]  = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,1,10,7, 0,0,2,1};
        vt[9]  = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,1, 1,1,10,7, 0,0,2,1};
        vt[10] = '{0,1,12, 0, 9,0,0,0, 4,1, 9,0, 1,0, 0,0, 0,0,0,0};
        vt[11] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,1, 1,1,12,0, 9,0,4,1};
        vt[12] = '{0,1,13, 0,20,0,0,1, 5,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[13] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,1, 1,1,13,0,20,1,5,1};
        vt[14] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[15] = '{0,1,14, 0,21,0,0,0, 6,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[16] = '{0,0, 0, 0, 0,0,0,0, 0,1,22,1, 1,0, 0,0, 0,0,0,1};
        vt[17] = '{0,0, 0, 0, 0,0,0,0, 0,1,21,1, 1,0, 0,0, 0,0,0,1};
        vt[18] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,1, 1,1,14,0,21,0,6,1};
        vt[19] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[20] = '{0,1,15, 0, 0,0,0,0, 7,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[21] = '{0,1,16, 0, 0,0,0,0, 8,0, 0,1, 1,1,15,0, 0,0,7,1};
        vt[22] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,1,16,0, 0,0,8,1};
        vt[23] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,1, 1,1,16,0, 0,0,8,1};
        vt[24] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[25] = '{0,1,17, 0, 0,0,0,0, 9,0, 0,0, 1,0, 0,0, 0,0,0,0};
        vt[26] = '{1,1,18, 0, 0,0,0,0,10,0, 0,1, 0,1,17,0, 0,0,9,1};
        vt[27] = '{0,0, 0, 0, 0,0,0,0, 0,0, 0,0, 1,0, 0,0, 0,0,0,0};

        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            if (vt[i].dv != 0)
                disp(vt[i].prd, vt[i].p1, vt[i].p2, vt[i].r1,
                     vt[i].r2, vt[i].src, vt[i].rob);
            bus.flush     = 1'(vt[i].fl);
            bus.wb_valid  = 1'(vt[i].wv);
            bus.wb_tag    = 6'(vt[i].wt);
            bus.iss_ready = 1'(vt[i].ir);
            #1;
            chk($sformatf("vec%0d", i), pack_act(), pack_exp(vt[i]));
            tick();
        end

        // Fill all eight entries while the ALU stalls.
        for (int i = 0; i < 8; i++) begin
            disp(40 + i, 0, 0, 0, 0, 0, i);
            #1;
            chk($sformatf("fill_rdy%0d", i), 96'(bus.disp_ready), 96'd1);
            tick();
        end
        #1;
        chk("full_occ", 96'(bus.occupancy), 96'd8);
        chk("full_rdy", 96'(bus.disp_ready), 96'd0);
        chk("full_oldest", 96'(bus.iss_prd), 96'd40);
        bus.iss_ready = 1'b1;
        #1;
        chk("full_issue_rdy", 96'(bus.disp_ready), 96'd0);
        tick();
        #1;
        chk("after_issue_rdy", 96'(bus.disp_ready), 96'd1);
        chk("after_issue_occ", 96'(bus.occupancy), 96'd7);
        for (int i = 1; i < 8; i++) begin
            bus.iss_ready = 1'b1;
            #1;
            chk($sformatf("drain%0d", i), 96'(bus.iss_prd), 96'(40 + i));
            tick();
        end
        #1;
        chk("drain_occ", 96'(bus.occupancy), 96'd0);

        // Younger entries placed in lower slots must still issue by age.
        disp(30, 50, 0, 0, 0, 0, 20); tick();
        disp(31, 51, 0, 0, 0, 0, 21); tick();
        disp(32, 52, 0, 0, 0, 0, 22); tick();
        bus.wb_valid = 1'b1; bus.wb_tag = 6'd51;
        #1;
        chk("age_wake_same", 96'(bus.iss_valid), 96'd0);
        tick();
        bus.iss_ready = 1'b1;
        #1;
        chk("age_blk1", 96'(bus.iss_prd), 96'd31);
        tick();
        disp(61, 0, 0, 0, 0, 0, 23); tick();
        disp(62, 0, 0, 0, 0, 0, 24); tick();
        bus.wb_valid = 1'b1; bus.wb_tag = 6'd50;
        #1;
        chk("age_t1_first", 96'(bus.iss_prd), 96'd61);
        tick();
        bus.iss_ready = 1'b1;
        #1;
        chk("age_blk0", 96'(bus.iss_prd), 96'd30);
        tick();
        disp(63, 0, 0, 0, 0, 0, 25);
        #1;
        chk("age_t3_disp", 96'(bus.iss_prd), 96'd61);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.iss_ready = 1'b1;
            #1;
            chk($sformatf("age_order%0d", i), 96'(bus.iss_prd), 96'(61 + i));
            tick();
        end
        bus.wb_valid = 1'b1; bus.wb_tag = 6'd52;
        #1;
        chk("age_blk2_wait", 96'(bus.iss_valid), 96'd0);
        tick();
        bus.iss_ready = 1'b1;
        #1;
        chk("age_blk2", 96'(bus.iss_prd), 96'd32);
        tick();
        #1;
        chk("age_occ", 96'(bus.occupancy), 96'd0);

        // Flush with five entries and a dispatch in the same cycle.
        for (int i = 0; i < 5; i++) begin
            disp(1 + i, 0, 0, 0, 0, 0, i);
            tick();
        end
        bus.flush = 1'b1;
        bus.iss_ready = 1'b1;
        disp(9, 0, 0, 0, 0, 0, 9);
        #1;
        chk("flush_state",
            96'({bus.disp_ready, bus.iss_valid, bus.iss_prd, bus.occupancy}),
            96'({1'b0, 1'b1, 6'd1, 4'd5}));
        tick();
        #1;
        chk("flush_after",
            96'({bus.disp_ready, bus.iss_valid, bus.occupancy}),
            96'({1'b1, 1'b0, 4'd0}));
        tick();
        #1;
        chk("flush_discard", 96'(bus.iss_valid), 96'd0);

        // Reset in mid-operation discards entries like a flush.
        disp(20, 0, 0, 0, 0, 0, 1); tick();
        disp(21, 0, 0, 0, 0, 0, 2); tick();
        reset_n = 1'b0;
        bus.iss_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        #1;
        chk("midreset",
            96'({bus.disp_ready, bus.iss_valid, bus.occupancy}),
            96'({1'b1, 1'b0, 4'd0}));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
